pro12_buttons_control_leds_led: RTL and testbench

PRO12_BUTTONS_CONTROL_LEDS_LED -- requirements
Module: pro12_buttons_control_leds_led

---
 rtl/pro12_leds_pkg.sv | 13 +
 rtl/pro12_led_blink_timer.sv | 31 +++
 rtl/pro12_buttons_control_leds_led.sv | 79 +++++++
 tb/tb_pro12_buttons_control_leds_led.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pro12_leds_pkg.sv
// Shared constants for the LED controller: Avalon-MM word addresses and
// the width of the blink half-period register.
package pro12_leds_pkg;

  localparam int PERIOD_W = 24;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/pro12_led_blink_timer.sv
// Blink timer: counts 0..period-1 and flips a shared phase on each wrap.
// A zero period parks the timer with phase high so blinking LEDs stay lit.
module pro12_led_blink_timer
  import pro12_leds_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_wr,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;
  logic                terminal;

  // >= keeps the counter from running away if it ever sits past the period
  assign terminal = (cnt >= period - PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (reset || period_wr || period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (terminal) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/pro12_buttons_control_leds_led.sv
// Avalon-MM LED controller: DATA/BLINK_EN/PERIOD registers with set/clear
// aliases, a registered read port and a registered blinking LED drive.
module pro12_buttons_control_leds_led
  import pro12_leds_pkg::*;
#(
  parameter int          WIDTH        = 4,
  parameter logic [31:0] RESET_VALUE  = 32'd0,
  parameter logic [31:0] PERIOD_RESET = 32'd25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    blink_q;
  logic [PERIOD_W-1:0] period_q;
  logic                phase;
  logic                wr;
  logic [WIDTH-1:0]    wd;
  logic [31:0]         rd_next;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, writedata[31:PERIOD_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE[WIDTH-1:0];
      blink_q  <= '0;
      period_q <= PERIOD_RESET[PERIOD_W-1:0];
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data_q   <= wd;
        ADDR_BLINK_EN: blink_q  <= wd;
        ADDR_PERIOD:   period_q <= writedata[PERIOD_W-1:0];
        ADDR_OUTSET:   data_q   <= data_q | wd;
        ADDR_OUTCLEAR: data_q   <= data_q & ~wd;
        default:       ;
      endcase
    end
  end

  pro12_led_blink_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .period    (period_q),
    .period_wr (wr && address == ADDR_PERIOD),
    .phase     (phase)
  );

  // Reads sample the registers before this edge's write lands
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0]    = data_q;
      ADDR_BLINK_EN: rd_next[WIDTH-1:0]    = blink_q;
      ADDR_PERIOD:   rd_next[PERIOD_W-1:0] = period_q;
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      out_port <= RESET_VALUE[WIDTH-1:0];
    end else begin
      readdata <= rd_next;
      out_port <= data_q & (~blink_q | {WIDTH{phase}});
    end
  end

endmodule

// File: tb/tb_pro12_buttons_control_leds_led.sv
// Directed + random bench for the LED controller, checked every cycle
// against a cycle-level behavioural model of the register map and blinker.
module tb_pro12_buttons_control_leds_led;

  localparam int          W   = 4;
  localparam logic [31:0] RV  = 32'h5;
  localparam logic [31:0] PRV = 32'd1000;

  logic        clk = 1'b0;
  logic        reset, chipselect, write_n;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [W-1:0] out_port;

  int checks = 0;
  int errors = 0;

  // model state
  logic [W-1:0] m_data, m_blink, m_out;
  int unsigned  m_period, m_cnt;
  bit           m_phase;
  logic [31:0]  m_rd;

  pro12_buttons_control_leds_led #(
    .WIDTH(W), .RESET_VALUE(RV), .PERIOD_RESET(PRV)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit c, input bit wn,
                       input logic [2:0] a, input logic [31:0] d);
    bit          wr;
    logic [31:0] rd;
    logic [W-1:0] o;
    wr = c && !wn;
    rd = 0;
    if (a == 0) rd = 32'(m_data);
    else if (a == 1) rd = 32'(m_blink);
    else if (a == 2) rd = m_period;
    for (int i = 0; i < W; i++) o[i] = m_data[i] && (!m_blink[i] || m_phase);
    m_rd  = r ? 32'h0 : rd;
    m_out = r ? RV[W-1:0] : o;
    if (r || (wr && a == 2) || m_period == 0) begin
      m_cnt = 0; m_phase = 1;
    end else if (m_cnt + 1 == m_period) begin
      m_cnt = 0; m_phase = !m_phase;
    end else m_cnt++;
    if (r) begin
      m_data = RV[W-1:0]; m_blink = 0; m_period = PRV & 32'hFF_FFFF;
    end else if (wr) begin
      case (a)
        3'd0: m_data   = d[W-1:0];
        3'd1: m_blink  = d[W-1:0];
        3'd2: m_period = d & 32'hFF_FFFF;
        3'd4: m_data   = m_data | d[W-1:0];
        3'd5: m_data   = m_data & ~d[W-1:0];
        default: ;
      endcase
    end
  endtask

  task automatic tick(input bit r, input bit c, input bit wn,
                      input logic [2:0] a, input logic [31:0] d);
    reset = r; chipselect = c; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    model(r, c, wn, a, d);
    #1;
    chk("out_port", 32'(out_port), 32'(m_out));
    chk("readdata", readdata, m_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    tick(0, 1, 0, a, d);
  endtask

  task automatic idle();
    tick(0, 0, 1, 3'd0, 0);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    tick(0, 1, 1, a, 0);
  endtask

  initial begin
    int last, n;
    logic prev;

    // reset state
    tick(1, 1, 0, 3'd0, 32'hF);
    tick(1, 0, 1, 3'd0, 0);
    chk("rst_out", 32'(out_port), 32'h5);
    chk("rst_rd", readdata, 0);
    rd_reg(0); chk("rst_data", readdata, 32'h5);
    rd_reg(1); chk("rst_blink", readdata, 32'h0);
    rd_reg(2); chk("rst_period", readdata, PRV);

    // write / set / clear, one cycle LED latency
    wr_reg(0, 32'hFFFF_FFFA);
    wr_reg(4, 32'h1); chk("out_after_data", 32'(out_port), 32'hA);
    wr_reg(5, 32'h8); chk("out_after_set", 32'(out_port), 32'hB);
    idle();           chk("out_after_clr", 32'(out_port), 32'h3);
    rd_reg(0);        chk("data_rb", readdata, 32'h3);
    wr_reg(0, 32'h6); chk("rbw_data", readdata, 32'h3);

    // blink with period 3 on bit 0
    wr_reg(2, 3); wr_reg(1, 1); wr_reg(0, 32'hF);
    idle(); idle();
    last = -1; prev = out_port[0];
    for (int i = 0; i < 30; i++) begin
      idle();
      chk("blink_hi_bits", 32'(out_port[3:1]), 32'h7);
      if (out_port[0] !== prev) begin
        if (last >= 0) chk("blink_gap", i - last, 3);
        last = i;
      end
      prev = out_port[0];
    end

    // period 0 holds everything lit
    wr_reg(2, 0); wr_reg(1, 32'hF);
    idle(); idle();
    for (int i = 0; i < 100; i++) begin
      idle();
      chk("period0_const", 32'(out_port), 32'hF);
    end

    // PERIOD write colliding with a terminal count
    wr_reg(2, 4);
    n = 0;
    while (m_cnt != 3 && n < 20) begin idle(); n++; end
    chk("reach_terminal", m_cnt, 3);
    wr_reg(2, 5);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("no_toggle", 32'(out_port), 32'hF);
    end
    idle(); chk("toggle_after_5", 32'(out_port), 32'h0);
    rd_reg(2); chk("period_rb", readdata, 5);

    // reset mid-blink with a concurrent DATA write
    idle(); idle();
    tick(1, 1, 0, 3'd0, 32'h0);
    chk("rst2_out", 32'(out_port), 32'h5);
    chk("rst2_rd", readdata, 0);
    rd_reg(0); chk("rst2_data", readdata, 32'h5);
    rd_reg(1); chk("rst2_blink", readdata, 0);
    rd_reg(2); chk("rst2_period", readdata, PRV);
    wr_reg(6, 32'hFFFF_FFFF);
    rd_reg(6); chk("rsvd_rd", readdata, 0);
    rd_reg(0); chk("rsvd_no_effect", readdata, 32'h5);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      tick($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), a,
           (a == 3'd2) ? 32'($urandom_range(0, 7)) : $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
